// File: rtl/dsp_pkg.sv
// Shared DSP definitions: accumulator width derivation, clamp limits and the
// settle/track state encoding used by the DC blocker.
package dsp_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        TRACK  = 1'b1
    } state_e;

    function automatic int unsigned accw(input int unsigned iw, input int unsigned k);
        return iw + k + 2;
    endfunction

    function automatic longint acc_hi(input int unsigned iw, input int unsigned k);
        return (longint'(1) <<< (iw - 1 + k)) - 1;
    endfunction

    function automatic longint acc_lo(input int unsigned iw, input int unsigned k);
        return -(longint'(1) <<< (iw - 1 + k));
    endfunction

endpackage

// File: rtl/dc_track_chan.sv
// One channel of the DC blocker: leaky-integrator DC estimate, subtraction and
// clamped accumulator update.
module dc_track_chan
    import dsp_pkg::*;
#(
    parameter int unsigned IW = 12,
    parameter int unsigned K  = 10,
    parameter int unsigned KF = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [IW-1:0] x,
    input  logic                 upd,
    input  logic                 fast,
    input  logic                 clr,
    output logic signed [IW:0]   e
);

    localparam int unsigned ACCW = accw(IW, K);
    localparam int unsigned AW1  = ACCW + 1;
    localparam int unsigned FS   = K - KF;
    localparam logic signed [AW1-1:0] HI_X = AW1'(acc_hi(IW, K));
    localparam logic signed [AW1-1:0] LO_X = AW1'(acc_lo(IW, K));

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [IW:0]     dc;
    logic signed [AW1-1:0]  step;
    logic signed [AW1-1:0]  sum;

    // The clamp keeps dc inside IW bits, so the top guard bit can be dropped.
    assign dc = acc_q[IW+K:K];
    assign e  = {x[IW-1], x} - dc;

    always_comb begin
        step = AW1'(e);
        if (fast) begin
            step = step <<< FS;
        end
        sum = AW1'(acc_q) + step;

        if (sum > HI_X) begin
            acc_d = HI_X[ACCW-1:0];
        end else if (sum < LO_X) begin
            acc_d = LO_X[ACCW-1:0];
        end else begin
            acc_d = sum[ACCW-1:0];
        end

        if (!upd) begin
            acc_d = acc_q;
        end
        if (clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dc_blocker.sv
// Dual-channel I/Q DC-offset removal: fast-settle then slow tracking of a
// per-channel DC estimate, output widened for the downstream saturator.
module dc_blocker
    import dsp_pkg::*;
#(
    parameter int unsigned IW = 12,
    parameter int unsigned OW = 17,
    parameter int unsigned K  = 10,
    parameter int unsigned KF = 4,
    parameter int unsigned SL = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_i,
    input  logic signed [IW-1:0] in_q,
    input  logic                 bypass,
    input  logic                 freeze,
    input  logic                 clear,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_i,
    output logic signed [OW-1:0] out_q,
    output logic                 settled
);

    logic                 s1_valid, s1_bypass, s1_freeze;
    logic signed [IW-1:0] s1_i, s1_q;
    logic signed [IW:0]   e_i, e_q;
    logic                 upd, fast;
    state_e               state_q, state_d;
    logic [SL-1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_freeze <= 1'b0;
            s1_i      <= '0;
            s1_q      <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_bypass <= bypass;
            s1_freeze <= freeze;
            s1_i      <= in_i;
            s1_q      <= in_q;
        end
    end

    assign upd  = s1_valid && !s1_bypass && !s1_freeze;
    assign fast = (state_q == SETTLE);

    dc_track_chan #(
        .IW (IW),
        .K  (K),
        .KF (KF)
    ) u_chan_i (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (s1_i),
        .upd   (upd),
        .fast  (fast),
        .clr   (clear),
        .e     (e_i)
    );

    dc_track_chan #(
        .IW (IW),
        .K  (K),
        .KF (KF)
    ) u_chan_q (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (s1_q),
        .upd   (upd),
        .fast  (fast),
        .clr   (clear),
        .e     (e_q)
    );

    // clear overrides any same-cycle sample accounting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (upd && state_q == SETTLE) begin
            cnt_d = cnt_q + SL'(1);
            if (cnt_q == '1) begin
                state_d = TRACK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign settled = (state_q == TRACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_i <= s1_bypass ? OW'(s1_i) : OW'(e_i);
                out_q <= s1_bypass ? OW'(s1_q) : OW'(e_q);
            end
        end
    end

endmodule

// File: tb/tb_dc_blocker.sv
// Self-checking bench for dc_blocker: randomized and directed stimulus checked
// against a sample-level arithmetic model of the DC estimator.
module tb_dc_blocker;

    localparam int IW = 12;
    localparam int OW = 17;
    localparam int K  = 10;
    localparam int KF = 4;
    localparam int SL = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [IW-1:0] in_i = '0;
    logic signed [IW-1:0] in_q = '0;
    logic                 bypass = 1'b0;
    logic                 freeze = 1'b0;
    logic                 clear = 1'b0;
    logic                 out_valid;
    logic signed [OW-1:0] out_i, out_q;
    logic                 settled;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dc_blocker #(
        .IW (IW),
        .OW (OW),
        .K  (K),
        .KF (KF),
        .SL (SL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .bypass    (bypass),
        .freeze    (freeze),
        .clear     (clear),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .settled   (settled)
    );

    // Reference model state: DC estimate scaled by 2^K, accepted-sample count.
    longint m_acc_i, m_acc_q;
    int     m_cnt;
    bit     m_settled;
    bit     pend_valid;
    int     pend_i, pend_q;
    bit     exp_valid;
    int     exp_i, exp_q;
    bit     exp_settled;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clampv(input longint a);
        longint lim;
        lim = longint'(1) << (IW - 1 + K);
        if (a > lim - 1) return lim - 1;
        if (a < -lim) return -lim;
        return a;
    endfunction

    task automatic model_reset();
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_settled = 0;
        pend_valid = 0; exp_valid = 0; exp_i = 0; exp_q = 0; exp_settled = 0;
    endtask

    task automatic model_clear();
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_settled = 0;
    endtask

    task automatic model_sample(input int xi, input int xq, input bit byp, input bit frz,
                                output int oi, output int oq);
        longint gain;
        int ei, eq;
        if (byp) begin
            oi = xi; oq = xq;
        end else begin
            ei = xi - int'(floor_div(m_acc_i, longint'(1) << K));
            eq = xq - int'(floor_div(m_acc_q, longint'(1) << K));
            oi = ei; oq = eq;
            if (!frz) begin
                gain = m_settled ? 1 : (longint'(1) << (K - KF));
                m_acc_i = clampv(m_acc_i + longint'(ei) * gain);
                m_acc_q = clampv(m_acc_q + longint'(eq) * gain);
                if (!m_settled) begin
                    m_cnt++;
                    if (m_cnt == (1 << SL)) m_settled = 1;
                end
            end
        end
    endtask

    // Drives one cycle of stimulus and advances the model to what the DUT shows after the edge.
    task automatic step(input bit v, input int xi, input int xq, input bit byp, input bit frz,
                        input bit clr);
        int oi, oq;
        @(negedge clk);
        in_valid = v; in_i = IW'(xi); in_q = IW'(xq);
        bypass = byp; freeze = frz; clear = clr;
        if (clr) model_clear();
        exp_settled = m_settled;
        exp_valid   = pend_valid;
        if (pend_valid) begin
            exp_i = pend_i; exp_q = pend_q;
        end
        if (v) begin
            model_sample(xi, xq, byp, frz, oi, oq);
            pend_valid = 1; pend_i = oi; pend_q = oq;
        end else begin
            pend_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_i !== '0) $display("FAIL reset_out_i: got %0d want 0", out_i); else n_pass++;
        n_checks++; if (out_q !== '0) $display("FAIL reset_out_q: got %0d want 0", out_q); else n_pass++;
        n_checks++; if (settled !== 1'b0) $display("FAIL reset_settled: got %0b want 0", settled); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_constant();
        int n = 0;
        for (int c = 0; c < 64 + 8 * 1024 + 4; c++) begin
            step(1, 1000, 0, 0, 0, 0);
            n_checks++; if (out_valid !== exp_valid) $display("FAIL const_valid: got %0b want %0b", out_valid, exp_valid); else n_pass++;
            n_checks++; if (int'(out_i) !== exp_i) $display("FAIL const_out_i: got %0d want %0d", out_i, exp_i); else n_pass++;
            n_checks++; if (settled !== exp_settled) $display("FAIL const_settled: got %0b want %0b", settled, exp_settled); else n_pass++;
            if (out_valid === 1'b1) begin
                n++;
                if (n == 1) begin
                    n_checks++; if (int'(out_i) !== 1000) $display("FAIL const_first: got %0d want 1000", out_i); else n_pass++;
                end
                if (n == 2) begin
                    n_checks++; if (int'(out_i) !== 938) $display("FAIL const_second: got %0d want 938", out_i); else n_pass++;
                end
                if (n == 63) begin
                    n_checks++; if (settled !== 1'b0) $display("FAIL settled_early: got %0b want 0", settled); else n_pass++;
                end
                if (n == 64) begin
                    n_checks++; if (settled !== 1'b1) $display("FAIL settled_rise: got %0b want 1", settled); else n_pass++;
                end
            end
        end
        n_checks++;
        if (int'(out_i) > 2 || int'(out_i) < -2) $display("FAIL const_converge: got %0d want within 2 of 0", out_i);
        else n_pass++;
    endtask

    task automatic test_neg_full();
        longint a;
        step(1, -2048, -2048, 0, 0, 1);
        for (int c = 0; c < 6000; c++) begin
            step(1, -2048, -2048, 0, 0, 0);
            n_checks++; if (int'(out_i) !== exp_i) $display("FAIL neg_out_i: got %0d want %0d", out_i, exp_i); else n_pass++;
            n_checks++; if (int'(out_q) !== exp_q) $display("FAIL neg_out_q: got %0d want %0d", out_q, exp_q); else n_pass++;
            a = longint'(dut.u_chan_i.acc_q);
            n_checks++;
            if (a < -(longint'(1) << 21) || a > (longint'(1) << 21) - 1) $display("FAIL neg_acc_range: got %0d want in clamp range", a);
            else n_pass++;
        end
        n_checks++;
        if (int'(out_i) !== 0 && int'(out_i) !== -1) $display("FAIL neg_converge_i: got %0d want 0 or -1", out_i); else n_pass++;
        n_checks++;
        if (int'(out_q) !== 0 && int'(out_q) !== -1) $display("FAIL neg_converge_q: got %0d want 0 or -1", out_q); else n_pass++;
    endtask

    task automatic test_bypass();
        int xs[10];
        for (int c = 0; c < 20; c++) begin
            step(1, rnd_sample(), rnd_sample(), 0, 0, 0);
            n_checks++; if (int'(out_i) !== exp_i) $display("FAIL byp_pre: got %0d want %0d", out_i, exp_i); else n_pass++;
        end
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                xs[i] = rnd_sample();
                step(1, xs[i], -xs[i], 1, 0, 0);
            end else begin
                step(0, 0, 0, 0, 0, 0);
            end
            if (i >= 1) begin
                n_checks++; if (int'(out_i) !== xs[i-1]) $display("FAIL byp_out_i: got %0d want %0d", out_i, xs[i-1]); else n_pass++;
                n_checks++; if (int'(out_q) !== -xs[i-1]) $display("FAIL byp_out_q: got %0d want %0d", out_q, -xs[i-1]); else n_pass++;
            end
        end
        for (int c = 0; c < 20; c++) begin
            step(1, rnd_sample(), rnd_sample(), 0, 0, 0);
            n_checks++; if (int'(out_i) !== exp_i) $display("FAIL byp_post_i: got %0d want %0d", out_i, exp_i); else n_pass++;
            n_checks++; if (int'(out_q) !== exp_q) $display("FAIL byp_post_q: got %0d want %0d", out_q, exp_q); else n_pass++;
            n_checks++; if (settled !== exp_settled) $display("FAIL byp_post_settled: got %0b want %0b", settled, exp_settled); else n_pass++;
        end
    endtask

    task automatic test_freeze();
        step(1, 500, 500, 0, 0, 1);
        for (int c = 0; c < 6000; c++) begin
            step(1, 500, 500, 0, 0, 0);
            n_checks++; if (int'(out_i) !== exp_i) $display("FAIL frz_pre_i: got %0d want %0d", out_i, exp_i); else n_pass++;
        end
        for (int i = 0; i < 11; i++) begin
            step(i < 10, 600, 600, 0, i < 10, 0);
            if (i >= 1) begin
                n_checks++; if (int'(out_i) !== 100) $display("FAIL frz_out_i: got %0d want 100", out_i); else n_pass++;
                n_checks++; if (int'(out_q) !== 100) $display("FAIL frz_out_q: got %0d want 100", out_q); else n_pass++;
            end
        end
        n_checks++;
        if (longint'(dut.u_chan_i.acc_q) !== m_acc_i) $display("FAIL frz_acc: got %0d want %0d", dut.u_chan_i.acc_q, m_acc_i);
        else n_pass++;
    endtask

    task automatic test_clear();
        for (int c = 0; c < 4; c++) step(1, 700, 700, 0, 0, 0);
        n_checks++; if (settled !== 1'b1) $display("FAIL clr_pre_settled: got %0b want 1", settled); else n_pass++;
        step(1, 250, -250, 0, 0, 1);
        n_checks++; if (int'(out_i) !== exp_i) $display("FAIL clr_old_dc: got %0d want %0d", out_i, exp_i); else n_pass++;
        n_checks++; if (settled !== 1'b0) $display("FAIL clr_settled_drop: got %0b want 0", settled); else n_pass++;
        step(0, 0, 0, 0, 0, 0);
        n_checks++; if (int'(out_i) !== 250) $display("FAIL clr_raw_i: got %0d want 250", out_i); else n_pass++;
        n_checks++; if (int'(out_q) !== -250) $display("FAIL clr_raw_q: got %0d want -250", out_q); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat;
        for (int c = 0; c < 6; c++) step(1, 100 + c, -100 - c, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_i !== '0) $display("FAIL arst_out_i: got %0d want 0", out_i); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        step(1, 300, -300, 0, 0, 0);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            step(0, 0, 0, 0, 0, 0);
            lat++;
        end
        n_checks++; if (lat !== 2) $display("FAIL arst_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (int'(out_i) !== exp_i) $display("FAIL arst_first_i: got %0d want %0d", out_i, exp_i); else n_pass++;
    endtask

    task automatic test_random();
        bit v, b, f, c;
        for (int n = 0; n < 2500; n++) begin
            v = ($urandom_range(3) != 0);
            b = ($urandom_range(9) == 0);
            f = ($urandom_range(9) == 0);
            c = ($urandom_range(99) == 0);
            step(v, rnd_sample(), rnd_sample(), b, f, c);
            n_checks++; if (out_valid !== exp_valid) $display("FAIL rnd_valid: got %0b want %0b", out_valid, exp_valid); else n_pass++;
            n_checks++; if (int'(out_i) !== exp_i) $display("FAIL rnd_out_i: got %0d want %0d", out_i, exp_i); else n_pass++;
            n_checks++; if (int'(out_q) !== exp_q) $display("FAIL rnd_out_q: got %0d want %0d", out_q, exp_q); else n_pass++;
            n_checks++; if (settled !== exp_settled) $display("FAIL rnd_settled: got %0b want %0b", settled, exp_settled); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_neg_full();
        test_bypass();
        test_freeze();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dc_blocker.md
# dc_blocker

Per-channel I/Q DC-offset removal stage between the ADC sample capture and the output saturator. A first-order leaky-integrator estimate of the DC level is subtracted from each sample. The result is emitted at a widened width for the saturator to clamp. A fast-settle phase after reset or clear converges the estimate quickly, then the block switches to a slow tracking time constant.

## Interface
- IW, 12, input sample width (signed)
- OW, 17, output sample width (signed); must be ≥ IW+1
- K, 10, tracking shift (time constant ≈ 2^K samples)
- KF, 4, fast-settle shift; 0 < KF ≤ K
- SL, 6, fast-settle length is 2^SL accepted samples
- clk  in  1  sample clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_i/in_q carry a new sample this cycle
- in_i, in_q  in  IW  signed input samples
- bypass  in  1  pass input through, estimator frozen
- freeze  in  1  hold estimate, keep subtracting
- clear  in  1  synchronous: zero estimate, restart fast-settle
- out_valid  out  1  out_i/out_q valid this cycle
- out_i, out_q  out  OW  signed corrected samples
- settled  out  1  high while in TRACK state

## Operation
- Each channel has an accumulator acc of width ACCW = IW+K+2. acc holds the DC estimate with K fractional bits. dc = acc >>> K (arithmetic, floor).
- Stage 1 registers in_i/in_q, in_valid, bypass and freeze.
- Stage 2 acts on a registered valid sample x:
  - e = x − dc, computed at IW+1 bits (cannot overflow).
  - Output is e sign-extended to OW.
  - Accumulator update: acc ← acc + (e <<< (K − s)), with s = KF in SETTLE and s = K in TRACK.
  - acc clamps to [−2^(IW−1)·2^K, (2^(IW−1))·2^K − 1].
- Bypass: output is x sign-extended to OW. acc, state and counter are held.
- Freeze: output is e. acc, state and counter are held.
- State machine, with a shared counter and FSM for both channels:
  - SETTLE: the counter increments on each accepted non-bypass, non-freeze sample. Move to TRACK when the counter reaches 2^SL−1 and a sample is accepted.
  - TRACK: remains here until clear.
  - clear, from any state: acc_i = acc_q = 0, counter = 0, state = SETTLE.
  - clear takes priority over a same-cycle sample update. The sample in stage 2 is still output, computed with the pre-clear dc.
- Reset values: acc = 0, counter = 0, state SETTLE, out_valid = 0, out_i = out_q = 0, settled = 0, stage-1 registers 0.

## Timing
- Latency is 2 cycles from in_valid to out_valid. Full throughput: in_valid may be high every cycle.
- out_i/out_q hold their value when out_valid = 0.
- bypass and freeze are sampled together with the sample, in stage 1. Each therefore applies to exactly the samples presented with it.
- clear acts at the clock edge on which it is high. The next sample's dc is 0.
- settled rises in the cycle after the transition edge into TRACK.
- An asynchronous reset assertion mid-stream drops the in-flight samples. out_valid is 0 immediately.
- Reset is released synchronously to clk, which is handled upstream.

## Structure
- Shared package dsp_pkg: ACCW derivation function, clamp limits, and a state enum {SETTLE, TRACK}.
- One sub-module is natural: dc_track_chan, which holds the per-channel acc, subtract and clamp logic. It is instantiated twice. The FSM and counter stay in the top level.
- The output feeds the existing saturator with ISZ = OW.

## Test plan
All scenarios use K=10, KF=4, SL=6.
- Constant x = 1000 on I, every cycle, from reset:
  - out_i sequence begins 1000, 938.
  - settled rises after 64 samples.
  - out_i within ±2 of 0 after 64 + 8·1024 samples.
- Constant x = −2048 on both channels:
  - No overflow.
  - acc never exceeds the clamp limits.
  - Outputs converge to 0 or −1.
- bypass high for 10 samples mid-stream:
  - out equals input sign-extended.
  - acc and counter are unchanged afterwards.
- freeze high with a settled dc of 500 and input 600:
  - out = 100 every sample.
  - acc is constant.
- clear asserted in the same cycle as a valid stage-2 sample:
  - That sample's output uses the old dc.
  - The next output equals the raw input.
  - settled drops the next cycle.
- Async reset asserted while in_valid streams:
  - out_valid drops immediately.
  - First out_valid after release appears exactly 2 cycles after the first new in_valid.
